// File: rtl/fib_seq_ctrl.sv
// Fibonacci fill sequencer: seeds entries 0/1 of a 64x32 register file, then
// fills 2..LAST with data[i] = data[i-2] + data[i-1] using only the file's ports.
module fib_seq_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int LAST   = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    output logic [ADDR_W-1:0] rAddr,
    input  logic [DATA_W-1:0] rDout,
    output logic [ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0] wDin,
    output logic              wEna,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [DATA_W-1:0] last_val
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEED0 = 3'd1;
    localparam logic [2:0] S_SEED1 = 3'd2;
    localparam logic [2:0] S_RD_A  = 3'd3;
    localparam logic [2:0] S_RD_B  = 3'd4;
    localparam logic [2:0] S_WR    = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(LAST);

    logic [2:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] seed0_q;
    logic [DATA_W-1:0] seed1_q;
    logic              overflow_q;
    logic [DATA_W-1:0] last_q;
    logic [DATA_W:0]   sum_full;

    // The extra top bit is the carry-out that feeds the sticky overflow flag.
    assign sum_full = {1'b0, reg_a} + {1'b0, reg_b};

    always_comb begin
        rAddr = '0;
        wAddr = '0;
        wDin  = '0;
        wEna  = 1'b0;
        case (state)
            S_SEED0: begin
                wEna = 1'b1;
                wDin = seed0_q;
            end
            S_SEED1: begin
                wEna  = 1'b1;
                wAddr = ADDR_W'(1);
                wDin  = seed1_q;
            end
            S_RD_A: rAddr = idx - ADDR_W'(2);
            S_RD_B: rAddr = idx - ADDR_W'(1);
            S_WR: begin
                wEna  = 1'b1;
                wAddr = idx;
                wDin  = sum_full[DATA_W-1:0];
            end
            default: ;
        endcase
    end

    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign done     = (state == S_DONE);
    assign overflow = overflow_q;
    assign last_val = last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= IDX_FIRST;
            reg_a      <= '0;
            reg_b      <= '0;
            seed0_q    <= '0;
            seed1_q    <= '0;
            overflow_q <= 1'b0;
            last_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        seed0_q    <= seed0;
                        seed1_q    <= seed1;
                        idx        <= IDX_FIRST;
                        overflow_q <= 1'b0;
                        state      <= S_SEED0;
                    end
                end
                S_SEED0: begin
                    last_q <= seed0_q;
                    state  <= S_SEED1;
                end
                S_SEED1: begin
                    last_q <= seed1_q;
                    state  <= S_RD_A;
                end
                S_RD_A: begin
                    reg_a <= rDout;
                    state <= S_RD_B;
                end
                S_RD_B: begin
                    reg_b <= rDout;
                    state <= S_WR;
                end
                S_WR: begin
                    last_q     <= sum_full[DATA_W-1:0];
                    overflow_q <= overflow_q | sum_full[DATA_W];
                    if (idx == IDX_LAST) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + ADDR_W'(1);
                        state <= S_RD_A;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Bench for fib_seq_ctrl: register-file models, a recurrence reference model
// and cycle-position expectations for the full and LAST=4 builds.
module tb_fib_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start_s, scramble, mon_on;
    logic [31:0] seed0, seed1, seed0_s, seed1_s;

    logic [5:0]  rAddr, wAddr, rAddr_s, wAddr_s;
    logic [31:0] rDout, wDin, last_val, rDout_s, wDin_s, last_val_s;
    logic        wEna, busy, done, overflow, wEna_s, busy_s, done_s, overflow_s;

    logic [31:0] mem [64];
    logic [31:0] mem_s [64];

    int errors = 0;
    int checks = 0;
    int mon_prints = 0;

    longint unsigned exp_val [64];
    bit              exp_ovf_after [64];
    logic            obs_ovf_after [64];

    fib_seq_ctrl #(.ADDR_W(6), .DATA_W(32), .LAST(63)) dut (
        .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1),
        .rAddr(rAddr), .rDout(rDout), .wAddr(wAddr), .wDin(wDin), .wEna(wEna),
        .busy(busy), .done(done), .overflow(overflow), .last_val(last_val)
    );

    fib_seq_ctrl #(.ADDR_W(6), .DATA_W(32), .LAST(4)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .seed0(seed0_s), .seed1(seed1_s),
        .rAddr(rAddr_s), .rDout(rDout_s), .wAddr(wAddr_s), .wDin(wDin_s), .wEna(wEna_s),
        .busy(busy_s), .done(done_s), .overflow(overflow_s), .last_val(last_val_s)
    );

    // Register files: read data is garbage while a write is in flight.
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 64; i++) begin
                mem[i]   <= $urandom;
                mem_s[i] <= $urandom;
            end
        end else begin
            if (wEna)   mem[wAddr]     <= wDin;
            if (wEna_s) mem_s[wAddr_s] <= wDin_s;
        end
    end
    assign rDout   = wEna   ? 32'hDEAD_BEEF : mem[rAddr];
    assign rDout_s = wEna_s ? 32'hDEAD_BEEF : mem_s[rAddr_s];

    // Protocol monitor for both instances.
    always @(negedge clk) begin
        if (!rst && mon_on) begin
            checks++;
            if ((wEna && (!busy || rAddr != 6'd0 || wAddr > 6'd63)) ||
                (!wEna && (wAddr != 6'd0 || wDin != 32'd0)) ||
                (wEna_s && (!busy_s || rAddr_s != 6'd0 || wAddr_s > 6'd4)) ||
                (!wEna_s && (wAddr_s != 6'd0 || wDin_s != 32'd0))) begin
                errors++;
                if (mon_prints < 4)
                    $display("FAIL protocol: got we=%0b busy=%0b ra=%0d wa=%0d wd=%0d / small we=%0b busy=%0b ra=%0d wa=%0d; want writes only while busy, ra=0 on writes, wa/wd=0 when idle, small wa<=4",
                             wEna, busy, rAddr, wAddr, wDin, wEna_s, busy_s, rAddr_s, wAddr_s);
                mon_prints++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by 1ms, want bench finished");
        $fatal(1, "watchdog");
    end

    function automatic void build_model(input logic [31:0] s0, input logic [31:0] s1, input int last);
        longint unsigned sum;
        exp_val[0] = s0;
        exp_val[1] = s1;
        exp_ovf_after[0] = 1'b0;
        exp_ovf_after[1] = 1'b0;
        for (int i = 2; i <= last; i++) begin
            sum = exp_val[i-2] + exp_val[i-1];
            exp_ovf_after[i] = exp_ovf_after[i-1] | (sum > 64'hFFFF_FFFF);
            exp_val[i] = sum & 64'hFFFF_FFFF;
        end
    endfunction

    // Starts a run from IDLE (at a negedge) and checks every cycle of it.
    task automatic drive_run(input logic [31:0] s0, input logic [31:0] s1,
                             input int pa, input int pb, input bit hold, input string tag);
        int done_cyc, bad, k, ph, ix, bad_mem;
        logic exp_we, exp_busy, exp_done, exp_ovf;
        logic [5:0] exp_wa, exp_ra;
        logic [31:0] exp_wd, exp_lv;
        bit chk_lv;
        build_model(s0, s1, 63);
        for (int i = 0; i < 64; i++) obs_ovf_after[i] = 1'bx;
        seed0 = s0;
        seed1 = s1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        seed0 = $urandom;
        seed1 = $urandom;
        done_cyc = 0;
        bad = 0;
        for (int c = 1; c <= 250 && done_cyc == 0; c++) begin
            exp_we = 0; exp_wa = 0; exp_wd = 0; exp_ra = 0; exp_busy = 1;
            exp_done = 0; exp_ovf = 0; exp_lv = 0; chk_lv = 1;
            if (c == 1) begin
                exp_we = 1; exp_wd = s0; chk_lv = 0;
            end else if (c == 2) begin
                exp_we = 1; exp_wa = 6'd1; exp_wd = s1; exp_lv = s0;
            end else if (c <= 188) begin
                k = (c - 3) / 3;
                ph = (c - 3) % 3;
                ix = k + 2;
                exp_ovf = exp_ovf_after[ix-1];
                exp_lv = 32'(exp_val[ix-1]);
                if (ph == 0) begin
                    exp_ra = 6'(ix - 2);
                    obs_ovf_after[ix-1] = overflow;
                end else if (ph == 1) begin
                    exp_ra = 6'(ix - 1);
                end else begin
                    exp_we = 1; exp_wa = 6'(ix); exp_wd = 32'(exp_val[ix]);
                end
            end else begin
                exp_busy = 0;
                exp_done = (c == 189);
                exp_ovf = exp_ovf_after[63];
                exp_lv = 32'(exp_val[63]);
                obs_ovf_after[63] = overflow;
            end
            checks++;
            if ({wEna, wAddr, wDin, rAddr, busy, done, overflow} !==
                {exp_we, exp_wa, exp_wd, exp_ra, exp_busy, exp_done, exp_ovf} ||
                (chk_lv && last_val !== exp_lv)) begin
                errors++;
                bad++;
                if (bad <= 4)
                    $display("FAIL %s cyc %0d: got we=%0b wa=%0d wd=%0d ra=%0d busy=%0b done=%0b ovf=%0b lv=%0d, want we=%0b wa=%0d wd=%0d ra=%0d busy=%0b done=%0b ovf=%0b lv=%0d",
                             tag, c, wEna, wAddr, wDin, rAddr, busy, done, overflow, last_val,
                             exp_we, exp_wa, exp_wd, exp_ra, exp_busy, exp_done, exp_ovf, exp_lv);
            end
            if (!hold) start = (c == pa || c == pb);
            if (done === 1'b1) done_cyc = c;
            else @(negedge clk);
        end
        checks++;
        if (done_cyc != 189) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d, want 189", tag, done_cyc);
        end
        bad_mem = -1;
        for (int i = 63; i >= 0; i--) if (mem[i] !== 32'(exp_val[i])) bad_mem = i;
        checks++;
        if (bad_mem >= 0) begin
            errors++;
            $display("FAIL %s contents: got entry%0d=%0d, want %0d", tag, bad_mem, mem[bad_mem], exp_val[bad_mem]);
        end
        if (!hold) begin
            start = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({wEna, busy, done, overflow, rAddr, wAddr, wDin, last_val} !== 72'd0 ||
            {wEna_s, busy_s, done_s, overflow_s, rAddr_s, wAddr_s, wDin_s, last_val_s} !== 72'd0) begin
            errors++;
            $display("FAIL reset_state: got we=%0b busy=%0b done=%0b ovf=%0b ra=%0d wa=%0d wd=%0d lv=%0d, want all 0",
                     wEna, busy, done, overflow, rAddr, wAddr, wDin, last_val);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wEna !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got busy=%0b we=%0b done=%0b, want 0 0 0", busy, wEna, done);
        end
    endtask

    task automatic test_seed_two_two;
        drive_run(32'd2, 32'd2, 0, 0, 1'b0, "seeds22");
        checks++;
        if (mem[2] !== 32'd4 || mem[3] !== 32'd6 || mem[4] !== 32'd10 || mem[10] !== 32'd178 ||
            mem[45] !== 32'd3672623806) begin
            errors++;
            $display("FAIL seeds22_values: got e2=%0d e3=%0d e4=%0d e10=%0d e45=%0d, want 4 6 10 178 3672623806",
                     mem[2], mem[3], mem[4], mem[10], mem[45]);
        end
        checks++;
        if (obs_ovf_after[45] !== 1'b0 || obs_ovf_after[46] !== 1'b1) begin
            errors++;
            $display("FAIL seeds22_ovf_rise: got after45=%0b after46=%0b, want 0 1", obs_ovf_after[45], obs_ovf_after[46]);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b1 || last_val !== 32'(exp_val[63])) begin
            errors++;
            $display("FAIL seeds22_after: got busy=%0b done=%0b ovf=%0b lv=%0d, want 0 0 1 %0d",
                     busy, done, overflow, last_val, exp_val[63]);
        end
    endtask

    task automatic test_seed_zero_one;
        drive_run(32'd0, 32'd1, 0, 0, 1'b0, "seeds01");
        checks++;
        if (mem[10] !== 32'd55 || mem[47] !== 32'd2971215073 || mem[48] !== 32'd512559680) begin
            errors++;
            $display("FAIL seeds01_values: got e10=%0d e47=%0d e48=%0d, want 55 2971215073 512559680",
                     mem[10], mem[47], mem[48]);
        end
        checks++;
        if (obs_ovf_after[47] !== 1'b0 || obs_ovf_after[48] !== 1'b1) begin
            errors++;
            $display("FAIL seeds01_ovf: got after47=%0b after48=%0b, want 0 1", obs_ovf_after[47], obs_ovf_after[48]);
        end
    endtask

    task automatic test_start_ignored;
        drive_run(32'd2, 32'd2, 50, 120, 1'b0, "restart_pulses");
    endtask

    task automatic test_mid_reset;
        logic [31:0] keep5;
        build_model(32'hF000_0000, 32'hF000_0000, 63);
        seed0 = 32'hF000_0000;
        seed1 = 32'hF000_0000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        keep5 = mem[5];
        checks++;
        if (rAddr !== 6'd4 || wEna !== 1'b0 || busy !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pos: got ra=%0d we=%0b busy=%0b ovf=%0b, want 4 0 1 1", rAddr, wEna, busy, overflow);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({wEna, busy, done, overflow, rAddr, wAddr, wDin, last_val} !== 72'd0) begin
            errors++;
            $display("FAIL mid_reset_state: got we=%0b busy=%0b done=%0b ovf=%0b ra=%0d lv=%0d, want all 0",
                     wEna, busy, done, overflow, rAddr, last_val);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (mem[5] !== keep5 || mem[4] !== 32'(exp_val[4]) || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_after: got e5=%0d e4=%0d busy=%0b, want %0d %0d 0", mem[5], mem[4], busy, keep5, exp_val[4]);
        end
        drive_run(32'd7, 32'd9, 0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back;
        drive_run(32'd11, 32'd13, 0, 0, 1'b1, "b2b_first");
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wEna !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got busy=%0b done=%0b we=%0b, want 0 0 0", busy, done, wEna);
        end
        drive_run(32'd1, 32'd4, 0, 0, 1'b0, "b2b_second");
    endtask

    task automatic test_random;
        for (int r = 0; r < 3; r++)
            drive_run($urandom, $urandom, $urandom_range(1, 188), $urandom_range(1, 188), 1'b0, "random");
    endtask

    task automatic test_small_last;
        logic [5:0]  wa_q [$];
        logic [31:0] wd_q [$];
        int done_cyc;
        build_model(32'd3, 32'd5, 4);
        seed0_s = 32'd3;
        seed1_s = 32'd5;
        start_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s = 1'b0;
        done_cyc = 0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            if (wEna_s) begin
                wa_q.push_back(wAddr_s);
                wd_q.push_back(wDin_s);
            end
            if (done_s === 1'b1) done_cyc = c;
            else @(negedge clk);
        end
        checks++;
        if (done_cyc != 12 || last_val_s !== 32'd21 || overflow_s !== 1'b0) begin
            errors++;
            $display("FAIL small_done: got cyc=%0d lv=%0d ovf=%0b, want 12 21 0", done_cyc, last_val_s, overflow_s);
        end
        checks++;
        if (wa_q.size() != 5) begin
            errors++;
            $display("FAIL small_count: got %0d writes, want 5", wa_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wa_q[i] !== 6'(i) || wd_q[i] !== 32'(exp_val[i])) begin
                    errors++;
                    $display("FAIL small_write%0d: got entry%0d=%0d, want entry%0d=%0d", i, wa_q[i], wd_q[i], i, exp_val[i]);
                end
            end
        end
        checks++;
        if (mem_s[2] !== 32'd8 || mem_s[3] !== 32'd13 || mem_s[4] !== 32'd21) begin
            errors++;
            $display("FAIL small_values: got %0d %0d %0d, want 8 13 21", mem_s[2], mem_s[3], mem_s[4]);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start_s = 1'b0;
        seed0 = '0;
        seed1 = '0;
        seed0_s = '0;
        seed1_s = '0;
        scramble = 1'b1;
        mon_on = 1'b0;
        repeat (3) @(negedge clk);
        scramble = 1'b0;
        test_reset();
        mon_on = 1'b1;
        test_seed_two_two();
        test_seed_zero_one();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        test_random();
        test_small_last();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
